// File: rtl/pong_gfx_pkg.sv
// rtl/pong_gfx_pkg.sv - shared state encoding, colours and sprite sequencing helper
package pong_gfx_pkg;

  typedef enum logic [3:0] {
    CLEAR,
    WAIT,
    SAMPLE,
    ERASE_L,
    ERASE_R,
    ERASE_B,
    DRAW_L,
    DRAW_R,
    DRAW_B
  } state_t;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  // Sprite slots in frame order: erase L/R/B then draw L/R/B; index 6 means frame complete.
  localparam int         NUM_SEQ  = 6;
  localparam logic [2:0] SEQ_DONE = 3'd6;

  function automatic logic [2:0] first_enabled(input logic [2:0] from, input logic [NUM_SEQ-1:0] en);
    logic [2:0] idx;
    idx = SEQ_DONE;
    for (int i = NUM_SEQ - 1; i >= 0; i--) begin
      if (en[i] && (3'(i) >= from)) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// rtl/pong_frame_timer.sv - free-running frame tick generator, one pulse every FRAME_CYCLES clocks
module pong_frame_timer #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_renderer.sv
// rtl/pong_renderer.sv - per-frame Pong sprite renderer emitting single-pixel writes over valid/ready
module pong_renderer
  import pong_gfx_pkg::*;
#(
  parameter int         X_W          = 6,
  parameter int         Y_W          = 5,
  parameter int         SCREEN_W     = 64,
  parameter int         SCREEN_H     = 32,
  parameter int         PADDLE_LEN   = 8,
  parameter int         BALL_SIZE    = 1,
  parameter int         FRAME_CYCLES = 833333,
  parameter logic [2:0] FG_COLOUR    = COLOUR_WHITE,
  parameter logic [2:0] BG_COLOUR    = COLOUR_BLACK,
  parameter int         SKIP_STATIC  = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [X_W-1:0] ball_x,
  input  logic [Y_W-1:0] ball_y,
  input  logic [Y_W-1:0] left_paddle_y,
  input  logic [Y_W-1:0] right_paddle_y,
  input  logic           clear_req,
  input  logic           plot_ready,
  output logic           plot,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           busy,
  output logic           frame_done,
  output logic           overrun
);

  localparam logic [X_W:0]   SCR_W   = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCR_H   = (Y_W+1)'(SCREEN_H);
  localparam logic [Y_W:0]   PAD_H   = (Y_W+1)'(PADDLE_LEN);
  localparam logic [X_W:0]   BALL_W  = (X_W+1)'(BALL_SIZE);
  localparam logic [Y_W:0]   BALL_H  = (Y_W+1)'(BALL_SIZE);
  localparam logic [X_W:0]   ONE_X   = (X_W+1)'(1);
  localparam logic [Y_W:0]   ONE_Y   = (Y_W+1)'(1);
  localparam logic [X_W-1:0] RIGHT_X = X_W'(SCREEN_W - 1);

  state_t         state_q, state_d;
  logic [X_W:0]   off_x_q, off_x_d;
  logic [Y_W:0]   off_y_q, off_y_d;
  logic [Y_W-1:0] this_l_q, this_l_d, this_r_q, this_r_d, this_by_q, this_by_d;
  logic [X_W-1:0] this_bx_q, this_bx_d;
  logic [Y_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d, last_by_q, last_by_d;
  logic [X_W-1:0] last_bx_q, last_bx_d;
  logic           last_valid_q, last_valid_d;
  logic           pending_q, pending_d;
  logic           clear_pend_q, clear_pend_d;
  logic           overrun_q, overrun_d;
  logic           frame_done_q, frame_done_d;

  logic               tick;
  logic               static_l, static_r, static_b;
  logic [NUM_SEQ-1:0] seq_en;
  logic               seq_step;
  logic [2:0]         seq_from, seq_next;
  logic [X_W-1:0]     base_x;
  logic [Y_W-1:0]     base_y;
  logic [X_W:0]       spr_w, px;
  logic [Y_W:0]       spr_h, py;
  logic [2:0]         spr_colour;
  logic               drawing, clipped, adv, last_pix;

  pong_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    this_l_d  = this_l_q;
    this_r_d  = this_r_q;
    this_bx_d = this_bx_q;
    this_by_d = this_by_q;
    if (state_q == SAMPLE) begin
      this_l_d  = left_paddle_y;
      this_r_d  = right_paddle_y;
      this_bx_d = ball_x;
      this_by_d = ball_y;
    end
  end

  // Skip decisions use the _d copies so SAMPLE can already pick the first sprite.
  always_comb begin
    static_l = (SKIP_STATIC != 0) && last_valid_q && (this_l_d == last_l_q);
    static_r = (SKIP_STATIC != 0) && last_valid_q && (this_r_d == last_r_q);
    static_b = (SKIP_STATIC != 0) && last_valid_q && (this_bx_d == last_bx_q) && (this_by_d == last_by_q);
    seq_en   = {!static_b, !static_r, !static_l,
                last_valid_q && !static_b, last_valid_q && !static_r, last_valid_q && !static_l};
  end

  always_comb begin
    base_x     = '0;
    base_y     = '0;
    spr_w      = ONE_X;
    spr_h      = PAD_H;
    spr_colour = BG_COLOUR;
    drawing    = 1'b1;
    case (state_q)
      CLEAR: begin
        spr_w = SCR_W;
        spr_h = SCR_H;
      end
      ERASE_L: base_y = last_l_q;
      ERASE_R: begin
        base_x = RIGHT_X;
        base_y = last_r_q;
      end
      ERASE_B: begin
        base_x = last_bx_q;
        base_y = last_by_q;
        spr_w  = BALL_W;
        spr_h  = BALL_H;
      end
      DRAW_L: begin
        base_y     = this_l_q;
        spr_colour = FG_COLOUR;
      end
      DRAW_R: begin
        base_x     = RIGHT_X;
        base_y     = this_r_q;
        spr_colour = FG_COLOUR;
      end
      DRAW_B: begin
        base_x     = this_bx_q;
        base_y     = this_by_q;
        spr_w      = BALL_W;
        spr_h      = BALL_H;
        spr_colour = FG_COLOUR;
      end
      default: drawing = 1'b0;
    endcase
  end

  // One extra bit keeps sprites hanging off the bottom/right edge from wrapping to row/column 0.
  assign px       = {1'b0, base_x} + off_x_q;
  assign py       = {1'b0, base_y} + off_y_q;
  assign clipped  = (px >= SCR_W) || (py >= SCR_H);
  assign adv      = drawing && (clipped || plot_ready);
  assign last_pix = (off_x_q == spr_w - ONE_X) && (off_y_q == spr_h - ONE_Y);

  always_comb begin
    state_d      = state_q;
    off_x_d      = off_x_q;
    off_y_d      = off_y_q;
    last_l_d     = last_l_q;
    last_r_d     = last_r_q;
    last_bx_d    = last_bx_q;
    last_by_d    = last_by_q;
    last_valid_d = last_valid_q;
    pending_d    = pending_q;
    clear_pend_d = clear_pend_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    seq_step     = 1'b0;
    seq_from     = '0;
    seq_next     = SEQ_DONE;

    if (tick) begin
      pending_d = 1'b1;
      if (pending_q) overrun_d = 1'b1;
    end
    if (clear_req && (state_q != CLEAR)) clear_pend_d = 1'b1;

    if (adv) begin
      if (last_pix) begin
        off_x_d = '0;
        off_y_d = '0;
      end else if (off_x_q == spr_w - ONE_X) begin
        off_x_d = '0;
        off_y_d = off_y_q + ONE_Y;
      end else begin
        off_x_d = off_x_q + ONE_X;
      end
    end

    case (state_q)
      WAIT: begin
        if (clear_pend_q) begin
          clear_pend_d = 1'b0;
          state_d      = CLEAR;
        end else if (pending_q) begin
          pending_d = tick;
          state_d   = SAMPLE;
        end
      end
      SAMPLE: seq_step = 1'b1;
      CLEAR: begin
        if (adv && last_pix) begin
          state_d      = WAIT;
          last_valid_d = 1'b0;
        end
      end
      default: begin
        if (adv && last_pix) begin
          seq_step = 1'b1;
          seq_from = 3'(4'(state_q) - 4'(ERASE_L) + 4'd1);
        end
      end
    endcase

    if (seq_step) begin
      seq_next = first_enabled(seq_from, seq_en);
      if (seq_next == SEQ_DONE) begin
        state_d      = WAIT;
        last_l_d     = this_l_d;
        last_r_d     = this_r_d;
        last_bx_d    = this_bx_d;
        last_by_d    = this_by_d;
        last_valid_d = 1'b1;
        frame_done_d = 1'b1;
      end else begin
        state_d = state_t'(4'(seq_next) + 4'(ERASE_L));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CLEAR;
      off_x_q      <= '0;
      off_y_q      <= '0;
      this_l_q     <= '0;
      this_r_q     <= '0;
      this_bx_q    <= '0;
      this_by_q    <= '0;
      last_l_q     <= '0;
      last_r_q     <= '0;
      last_bx_q    <= '0;
      last_by_q    <= '0;
      last_valid_q <= 1'b0;
      pending_q    <= 1'b0;
      clear_pend_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_x_q      <= off_x_d;
      off_y_q      <= off_y_d;
      this_l_q     <= this_l_d;
      this_r_q     <= this_r_d;
      this_bx_q    <= this_bx_d;
      this_by_q    <= this_by_d;
      last_l_q     <= last_l_d;
      last_r_q     <= last_r_d;
      last_bx_q    <= last_bx_d;
      last_by_q    <= last_by_d;
      last_valid_q <= last_valid_d;
      pending_q    <= pending_d;
      clear_pend_q <= clear_pend_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Gating with reset drops plot combinationally the moment reset asserts.
  assign plot       = drawing && !clipped && reset;
  assign x          = px[X_W-1:0];
  assign y          = py[Y_W-1:0];
  assign colour     = spr_colour;
  assign busy       = (state_q != WAIT);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pong_renderer.sv
// tb/tb_pong_renderer.sv - self-checking bench for pong_renderer against a pixel-list reference model
module tb_pong_renderer;

  localparam int         X_W = 6;
  localparam int         Y_W = 5;
  localparam int         SW  = 64;
  localparam int         SH  = 32;
  localparam int         PL  = 8;
  localparam int         BS  = 2;
  localparam int         FC  = 2200;
  localparam logic [2:0] FG  = 3'b111;
  localparam logic [2:0] BG  = 3'b000;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic           clk;
  logic           reset;
  logic [X_W-1:0] ball_x;
  logic [Y_W-1:0] ball_y;
  logic [Y_W-1:0] left_paddle_y;
  logic [Y_W-1:0] right_paddle_y;
  logic           clear_req;
  logic           plot_ready;
  logic           plot;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     colour;
  logic           busy;
  logic           frame_done;
  logic           overrun;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   ready_mode = 0;
  pix_t got_q[$];
  pix_t exp_q[$];

  int m_l, m_r, m_bx, m_by;
  bit m_valid;

  bit             stall_seen = 0;
  logic [X_W-1:0] st_x;
  logic [Y_W-1:0] st_y;
  logic [2:0]     st_c;

  pong_renderer #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SW), .SCREEN_H(SH), .PADDLE_LEN(PL), .BALL_SIZE(BS),
    .FRAME_CYCLES(FC), .FG_COLOUR(FG), .BG_COLOUR(BG), .SKIP_STATIC(1)
  ) dut (
    .clk(clk), .reset(reset), .ball_x(ball_x), .ball_y(ball_y),
    .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
    .clear_req(clear_req), .plot_ready(plot_ready), .plot(plot), .x(x), .y(y),
    .colour(colour), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    plot_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 1)      plot_ready = 1'($urandom_range(0, 1));
      else if (ready_mode == 2) plot_ready = 1'b0;
      else                      plot_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset && plot && plot_ready) got_q.push_back('{int'(x), int'(y), int'(colour)});
    if (reset && stall_seen) begin
      tests_run++;
      assert (plot === 1'b1 && x === st_x && y === st_y && colour === st_c) else begin
        tests_failed++;
        $error("FAIL stall_hold: got plot=%0b (%0d,%0d,c%0d) expected plot=1 (%0d,%0d,c%0d)",
               plot, x, y, colour, st_x, st_y, st_c);
      end
    end
    stall_seen = reset && plot && !plot_ready;
    st_x = x;
    st_y = y;
    st_c = colour;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_rect(input int bx, input int by, input int w, input int h, input int c);
    for (int r = 0; r < h; r++)
      for (int col = 0; col < w; col++)
        if (bx + col < SW && by + r < SH) exp_q.push_back('{bx + col, by + r, c});
  endtask

  task automatic model_clear();
    add_rect(0, 0, SW, SH, int'(BG));
    m_valid = 0;
  endtask

  task automatic model_frame(input int l, input int r, input int bx, input int by);
    bit sl, sr, sb;
    sl = m_valid && (l == m_l);
    sr = m_valid && (r == m_r);
    sb = m_valid && (bx == m_bx) && (by == m_by);
    if (m_valid && !sl) add_rect(0, m_l, 1, PL, int'(BG));
    if (m_valid && !sr) add_rect(SW - 1, m_r, 1, PL, int'(BG));
    if (m_valid && !sb) add_rect(m_bx, m_by, BS, BS, int'(BG));
    if (!sl) add_rect(0, l, 1, PL, int'(FG));
    if (!sr) add_rect(SW - 1, r, 1, PL, int'(FG));
    if (!sb) add_rect(bx, by, BS, BS, int'(FG));
    m_l = l;
    m_r = r;
    m_bx = bx;
    m_by = by;
    m_valid = 1;
  endtask

  task automatic set_pos(input int l, input int r, input int bx, input int by);
    left_paddle_y  = Y_W'(l);
    right_paddle_y = Y_W'(r);
    ball_x         = X_W'(bx);
    ball_y         = Y_W'(by);
  endtask

  task automatic compare_pixels(input string tag);
    int n;
    bit bad;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    bad = 0;
    for (int i = 0; i < n && !bad; i++) begin
      tests_run++;
      assert (got_q[i].x == exp_q[i].x && got_q[i].y == exp_q[i].y && got_q[i].c == exp_q[i].c) else begin
        tests_failed++;
        bad = 1;
        $error("FAIL %s pixel %0d: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)", tag, i,
               got_q[i].x, got_q[i].y, got_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_busy(input logic lvl, input int bound, input string tag);
    int n;
    n = 0;
    while (busy !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, lvl);
  endtask

  task automatic wait_frame_done(input int bound, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < bound);
    check({tag, "_done"}, frame_done, 1);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int l, r, bx, by;
    bit found;

    reset = 1'b1;
    clear_req = 1'b0;
    set_pos(0, 0, 0, 0);
    m_valid = 0;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_plot", plot, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, BG);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 1);

    reset = 1'b1;
    model_clear();
    wait_busy(0, 3000, "clear_end");
    compare_pixels("clear");

    set_pos(4, 10, 30, 15);
    model_frame(4, 10, 30, 15);
    wait_frame_done(3 * FC, "frame1");
    compare_pixels("frame1");
    @(negedge clk);
    check("frame1_pulse_width", frame_done, 0);
    check("frame1_no_overrun", overrun, 0);

    set_pos(5, 10, 30, 15);
    model_frame(5, 10, 30, 15);
    wait_frame_done(3 * FC, "frame2");
    compare_pixels("frame2_left_only");

    set_pos(5, 28, 30, 15);
    model_frame(5, 28, 30, 15);
    wait_frame_done(3 * FC, "frame3");
    compare_pixels("frame3_clip");

    set_pos(5, 28, 63, 31);
    model_frame(5, 28, 63, 31);
    wait_frame_done(3 * FC, "frame4");
    compare_pixels("frame4_ball_clip");

    ready_mode = 1;
    for (int f = 0; f < 6; f++) begin
      l  = ($urandom_range(0, 1) == 0) ? m_l  : int'($urandom_range(0, 31));
      r  = ($urandom_range(0, 1) == 0) ? m_r  : int'($urandom_range(0, 31));
      bx = ($urandom_range(0, 1) == 0) ? m_bx : int'($urandom_range(0, 63));
      by = ($urandom_range(0, 1) == 0) ? m_by : int'($urandom_range(0, 31));
      set_pos(l, r, bx, by);
      model_frame(l, r, bx, by);
      wait_frame_done(3 * FC, "rand_frame");
      compare_pixels("rand_frame");
    end
    check("rand_no_overrun", overrun, 0);

    ready_mode = 2;
    l = (m_l + 3) % 24;
    set_pos(l, 2, 20, 20);
    model_frame(l, 2, 20, 20);
    wait_busy(1, 3 * FC, "overrun_start");
    repeat (3 * FC) @(negedge clk);
    check("overrun_set", overrun, 1);
    ready_mode = 0;
    wait_frame_done(3 * FC, "overrun_frame");
    compare_pixels("overrun_frame");
    model_frame(l, 2, 20, 20);
    wait_frame_done(2 * FC, "overrun_static");
    compare_pixels("overrun_static");

    l = (m_l + 5) % 24;
    set_pos(l, 2, 20, 20);
    model_frame(l, 2, 20, 20);
    found = 0;
    for (int n = 0; n < 3 * FC && !found; n++) begin
      @(negedge clk);
      if (plot === 1'b1 && colour === FG && x === '0) found = 1;
    end
    check("clear_req_seen_draw_l", found, 1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_frame_done(3 * FC, "clear_req_frame");
    compare_pixels("clear_req_frame");
    model_clear();
    wait_busy(1, 10, "clear_req_start");
    wait_busy(0, 3000, "clear_req_end");
    compare_pixels("clear_req_clear");
    model_frame(l, 2, 20, 20);
    wait_frame_done(3 * FC, "after_clear");
    compare_pixels("after_clear_full_draw");

    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_busy(1, 10, "mid_clear_start");
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_clear_plot_drop", plot, 0);
    check("mid_clear_x", x, 0);
    check("mid_clear_y", y, 0);
    check("mid_clear_overrun", overrun, 0);
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    wait_busy(0, 3000, "restart_clear_end");
    compare_pixels("restart_clear");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
